// File: rtl/mem_loader.sv
`timescale 1ns / 1ps
// mem_loader: boot-time program loader.
// Collects bytes from the UART receiver, packs them big-endian into 32-bit words and writes
// each word to consecutive addresses of the word-addressed memory. A load ends after the
// halt word has been written, or after the last address has been written (o_full).
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             one-cycle pulse that begins (or restarts) a load
//   i_rx_data/valid     received byte and its one-cycle strobe
//   o_en, o_w_en        memory enable / byte write enables, high for one cycle per word
//   o_addr, o_w_data    word address and assembled word
//   o_busy, o_done      loading in progress / load finished
//   o_full              load ended on the last address without a halt word
//   o_word_count        words written in the current or last load
module mem_loader #(
    parameter int unsigned          NB_DATA    = 32,
    parameter int unsigned          N_ADDRESS  = 32,
    parameter int unsigned          NB_ADDRESS = $clog2(N_ADDRESS),
    parameter logic [NB_DATA-1:0]   HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_en,
    output logic [3:0]            o_w_en,
    output logic [NB_ADDRESS-1:0] o_addr,
    output logic [NB_DATA-1:0]    o_w_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_full,
    output logic [NB_ADDRESS:0]   o_word_count
);

    localparam logic [NB_ADDRESS-1:0] LastAddr = NB_ADDRESS'(N_ADDRESS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    // Only the first three bytes need storing; the fourth goes straight into w_data.
    logic [NB_DATA-9:0]      word_q, word_d;
    logic [NB_DATA-1:0]      w_data_q, w_data_d;
    logic [NB_ADDRESS-1:0]   addr_q, addr_d;
    logic [NB_ADDRESS:0]     word_count_q, word_count_d;
    logic                    en_q, en_d;
    logic [3:0]              w_en_q, w_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    full_q, full_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            word_q       <= '0;
            w_data_q     <= '0;
            addr_q       <= '0;
            word_count_q <= '0;
            en_q         <= 1'b0;
            w_en_q       <= 4'h0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            w_data_q     <= w_data_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            en_q         <= en_d;
            w_en_q       <= w_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            full_q       <= full_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        w_data_d     = w_data_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        en_d         = 1'b0;
        w_en_d       = 4'h0;
        busy_d       = busy_q;
        done_d       = done_q;
        full_d       = full_q;

        unique case (state_q)
            StIdle, StDone: begin
                // Bytes are ignored here, including one coinciding with i_start.
                if (i_start) begin
                    state_d      = StRecv;
                    cnt_d        = '0;
                    addr_d       = '0;
                    word_count_d = '0;
                    full_d       = 1'b0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                end
            end

            StRecv: begin
                if (i_rx_valid) begin
                    word_d = {word_q[NB_DATA-17:0], i_rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d  = StWrite;
                        w_data_d = {word_q, i_rx_data};
                        en_d     = 1'b1;
                        w_en_d   = 4'hF;
                    end
                end
            end

            StWrite: begin
                word_count_d = word_count_q + (NB_ADDRESS + 1)'(1);
                if (w_data_q == HALT_WORD || addr_q == LastAddr) begin
                    // Any byte arriving now is discarded.
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    full_d  = (w_data_q != HALT_WORD);
                end else begin
                    state_d = StRecv;
                    addr_d  = addr_q + NB_ADDRESS'(1);
                    // A byte in the write cycle starts the next word.
                    if (i_rx_valid) begin
                        word_d = {word_q[NB_DATA-17:0], i_rx_data};
                        cnt_d  = 2'd1;
                    end else begin
                        cnt_d  = 2'd0;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    assign o_en         = en_q;
    assign o_w_en       = w_en_q;
    assign o_addr       = addr_q;
    assign o_w_data     = w_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_full       = full_q;
    assign o_word_count = word_count_q;

endmodule

// File: tb/tb_mem_loader.sv
`timescale 1ns / 1ps
// Testbench for mem_loader (N_ADDRESS = 4). Expected memory writes are queued as stimulus is
// driven; a negedge monitor pops and compares them whenever o_en is high.
module tb_mem_loader;

    localparam int unsigned NA = 4;
    localparam int unsigned NB = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          en;
    logic [3:0]    w_en;
    logic [NB-1:0] addr;
    logic [31:0]   w_data;
    logic          busy;
    logic          done;
    logic          full;
    logic [NB:0]   word_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NB-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t  exp_q[$];
    logic prev_en = 1'b0;

    mem_loader #(
        .NB_DATA   (32),
        .N_ADDRESS (NA)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_en         (en),
        .o_w_en       (w_en),
        .o_addr       (addr),
        .o_w_data     (w_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_full       (full),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    // Write monitor / scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            prev_en = 1'b0;
        end else begin
            if (en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                             addr, w_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({addr, w_data} !== {e.addr, e.data}) begin
                        errors++;
                        $display("FAIL write_content: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 addr, w_data, e.addr, e.data);
                    end
                end
                checks++;
                if (w_en !== 4'hF) begin
                    errors++;
                    $display("FAIL w_en_in_write: got %h, expected f", w_en);
                end
                checks++;
                if (prev_en) begin
                    errors++;
                    $display("FAIL en_consecutive: got o_en high two cycles, expected one");
                end
            end else begin
                checks++;
                if (w_en !== 4'h0) begin
                    errors++;
                    $display("FAIL w_en_idle: got %h, expected 0", w_en);
                end
            end
            prev_en = en;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Push the expected write (if any), then send the four bytes back to back.
    task automatic send_word(input logic [31:0] w, input logic expect_wr, input logic [NB-1:0] a);
        wr_t e;
        if (expect_wr) begin
            e.addr = a;
            e.data = w;
            exp_q.push_back(e);
        end
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d writes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        checks++;
        if ({en, w_en, addr, w_data, busy, done, full, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_initial: got outputs nonzero, expected all 0");
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Mid-word reset without a clock edge.
        pulse_start();
        send_byte(8'hDE);
        send_byte(8'hAD);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en, w_en, addr, w_data, busy, done, full, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_async: got busy=%b addr=%0d, expected all 0", busy, addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({en, w_en, addr, w_data, busy, done, full, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_held_edge: got busy=%b, expected all 0", busy);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Partial word was lost: a fresh word lands intact at address 0.
        pulse_start();
        send_word(32'h11223344, 1'b1, 2'd0);
        drain("reset_partial");
        // Reset in the write cycle kills o_en at once and counts nothing.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        send_word(32'h55667788, 1'b0, 2'd0);
        checks++;
        if (en !== 1'b1) begin
            errors++;
            $display("FAIL reset_write_setup: got o_en=%b, expected 1", en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en, w_en, word_count, busy} !== '0) begin
            errors++;
            $display("FAIL reset_in_write: got en=%b w_en=%h count=%0d, expected 0",
                     en, w_en, word_count);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_load();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b, expected 1", busy);
        end
        send_word(32'h12345678, 1'b1, 2'd0);
        checks++;
        if (en !== 1'b1) begin
            errors++;
            $display("FAIL basic_write_timing: got o_en=%b, expected 1", en);
        end
        send_word(32'hABCDEF01, 1'b1, 2'd1);
        send_word(32'hFFFFFFFF, 1'b1, 2'd2);
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy, full, word_count} !== {1'b1, 1'b0, 1'b0, 3'd3}) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b full=%b count=%0d, expected 1 0 0 3",
                     done, busy, full, word_count);
        end
        drain("basic");
    endtask

    task automatic test_byte_during_write();
        pulse_start();
        send_word(32'h00000001, 1'b1, 2'd0);
        // Fifth byte arrives in the write cycle.
        send_word(32'hAABBCCDD, 1'b1, 2'd1);
        repeat (3) @(posedge clk);
        #1;
        send_word(32'hFFFFFFFF, 1'b1, 2'd2);
        @(posedge clk);
        #1;
        checks++;
        if ({done, word_count} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL bdw_done: got done=%b count=%0d, expected 1 3", done, word_count);
        end
        drain("bdw");
    endtask

    task automatic test_full();
        pulse_start();
        send_word(32'h01010101, 1'b1, 2'd0);
        send_word(32'h02020202, 1'b1, 2'd1);
        send_word(32'h03030303, 1'b1, 2'd2);
        send_word(32'h04040404, 1'b1, 2'd3);
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy, full, word_count, addr} !== {1'b1, 1'b0, 1'b1, 3'd4, 2'd3}) begin
            errors++;
            $display("FAIL full_done: got done=%b busy=%b full=%b count=%0d addr=%0d, expected 1 0 1 4 3",
                     done, busy, full, word_count, addr);
        end
        send_word(32'h05050505, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({done, full, word_count, addr} !== {1'b1, 1'b1, 3'd4, 2'd3}) begin
            errors++;
            $display("FAIL full_hold: got done=%b full=%b count=%0d addr=%0d, expected 1 1 4 3",
                     done, full, word_count, addr);
        end
        drain("full");
    endtask

    task automatic test_ignored_inputs();
        // Start and byte together in DONE: the byte is dropped.
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        start    = 1'b0;
        checks++;
        if ({busy, done, full, word_count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL ign_start_done: got busy=%b done=%b full=%b count=%0d, expected 1 0 0 0",
                     busy, done, full, word_count);
        end
        send_word(32'h10203040, 1'b1, 2'd0);
        // Start mid-word in RECV is ignored.
        exp_q.push_back('{addr: 2'd1, data: 32'h50607080});
        send_byte(8'h50);
        send_byte(8'h60);
        pulse_start();
        send_byte(8'h70);
        send_byte(8'h80);
        send_word(32'hFFFFFFFF, 1'b1, 2'd2);
        drain("ign_recv");
        // Bytes in IDLE are ignored.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        send_byte(8'hC5);
        checks++;
        if ({busy, addr, word_count} !== '0) begin
            errors++;
            $display("FAIL ign_idle: got busy=%b addr=%0d count=%0d, expected 0",
                     busy, addr, word_count);
        end
        pulse_start();
        send_word(32'h01020304, 1'b1, 2'd0);
        send_word(32'hFFFFFFFF, 1'b1, 2'd1);
        drain("ign_idle");
    endtask

    task automatic test_restart();
        @(posedge clk);
        #1;
        pulse_start();
        checks++;
        if ({done, full, word_count, busy} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL restart_clear: got done=%b full=%b count=%0d busy=%b, expected 0 0 0 1",
                     done, full, word_count, busy);
        end
        send_word(32'hCAFEF00D, 1'b1, 2'd0);
        send_word(32'hFFFFFFFF, 1'b1, 2'd1);
        @(posedge clk);
        #1;
        checks++;
        if ({done, word_count} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL restart_done: got done=%b count=%0d, expected 1 2", done, word_count);
        end
        drain("restart");
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_byte_during_write();
        test_full();
        test_ignored_inputs();
        test_restart();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
